// File: rtl/i2s_tdm_unit.sv
// i2s_tdm_unit: parameterised I2S / left-justified multi-channel serial audio transmitter
module i2s_tdm_unit #(
    parameter int DATA_WIDTH = 24,
    parameter int CHANNELS   = 2,
    parameter int SCK_DIV    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           play_in,
    input  logic                           fmt_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] audio_in,
    input  logic                           tick_in,
    output logic                           req_out,
    output logic                           sck_out,
    output logic                           ws_out,
    output logic                           sdo_out,
    output logic                           underrun_out
);
    localparam int FB = CHANNELS * DATA_WIDTH;
    localparam int FC = FB * SCK_DIV;
    localparam int H  = SCK_DIV / 2;
    localparam int CW = $clog2(FC);
    localparam int PW = $clog2(SCK_DIV);
    localparam int WW = $clog2(FB);
    localparam logic [CW-1:0] C_LAST = CW'(FC - 1);
    localparam logic [CW-1:0] C_LOAD = CW'(FC - H);
    localparam logic [PW-1:0] P_LAST = PW'(SCK_DIV - 1);
    localparam logic [PW-1:0] P_H    = PW'(H);
    localparam logic [WW-1:0] W_LAST = WW'(FB - 1);
    localparam logic [WW-1:0] W_HALF = WW'(FB / 2);

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

    state_t          state;
    logic [CW-1:0]   ctr, ctr_n;
    logic [PW-1:0]   ph, ph_n;
    logic [WW-1:0]   win, win_n;
    logic [FB-1:0]   input_reg, shift_reg, nf;
    logic            fmt_r, fresh, fall, at_load, bit_lj, bit_i2s;

    // shift_reg holds the frame word with ch0 in the top bits so bit FB-1-w is window w
    function automatic logic [FB-1:0] to_frame(input logic [FB-1:0] a);
        logic [FB-1:0] f;
        f = '0;
        for (int c = 0; c < CHANNELS; c++)
            f[(CHANNELS-1-c)*DATA_WIDTH +: DATA_WIDTH] = a[c*DATA_WIDTH +: DATA_WIDTH];
        return f;
    endfunction

    // next counter values, sck-falling detect and the candidate serial bits
    always_comb begin
        ctr_n   = (ctr == C_LAST) ? '0 : ctr + 1'b1;
        ph_n    = (ph == P_LAST) ? '0 : ph + 1'b1;
        fall    = (ph_n == P_H);
        win_n   = fall ? ((win == W_LAST) ? '0 : win + 1'b1) : win;
        at_load = (ctr_n == C_LOAD);
        nf      = to_frame(tick_in ? audio_in : input_reg);
        bit_lj  = shift_reg[W_LAST - win_n];
        bit_i2s = shift_reg[W_LAST - win_n + 1'b1];
    end

    // frame FSM; every output is computed for the cycle it appears in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ctr          <= '0;
            ph           <= '0;
            win          <= '0;
            input_reg    <= '0;
            shift_reg    <= '0;
            fmt_r        <= 1'b0;
            fresh        <= 1'b0;
            req_out      <= 1'b0;
            sck_out      <= 1'b0;
            ws_out       <= 1'b0;
            sdo_out      <= 1'b0;
            underrun_out <= 1'b0;
        end else begin
            if (tick_in) begin
                input_reg <= audio_in;
                fresh     <= 1'b1;
            end
            req_out      <= 1'b0;
            underrun_out <= 1'b0;
            case (state)
                IDLE: begin
                    ctr     <= '0;
                    ph      <= '0;
                    win     <= '0;
                    sck_out <= 1'b0;
                    ws_out  <= 1'b0;
                    sdo_out <= 1'b0;
                    if (play_in) begin
                        state     <= PLAY;
                        fmt_r     <= fmt_in;
                        sck_out   <= 1'b1;
                        req_out   <= 1'b1;
                        shift_reg <= nf;
                        fresh     <= 1'b0;
                        sdo_out   <= fmt_in & nf[FB-1];
                    end
                end
                PLAY, DRAIN: begin
                    if (state == DRAIN && ctr == C_LAST) begin
                        state     <= IDLE;
                        ctr       <= '0;
                        ph        <= '0;
                        win       <= '0;
                        sck_out   <= 1'b0;
                        ws_out    <= 1'b0;
                        sdo_out   <= 1'b0;
                        input_reg <= '0;
                        shift_reg <= '0;
                        fresh     <= 1'b0;
                    end else begin
                        if (state == PLAY && !play_in)
                            state <= DRAIN;
                        ctr     <= ctr_n;
                        ph      <= ph_n;
                        win     <= win_n;
                        sck_out <= (ph_n < P_H);
                        if (fall) begin
                            if (!at_load) begin
                                ws_out  <= (win_n >= W_HALF);
                                sdo_out <= fmt_r ? bit_lj : bit_i2s;
                            end else if (state == PLAY && play_in) begin
                                shift_reg    <= nf;
                                req_out      <= 1'b1;
                                underrun_out <= !fresh && !tick_in;
                                fresh        <= 1'b0;
                                ws_out       <= 1'b0;
                                sdo_out      <= fmt_r ? nf[FB-1] : shift_reg[0];
                            end else begin
                                ws_out  <= 1'b0;
                                sdo_out <= !fmt_r & shift_reg[0];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_tdm_unit.sv
// tb_i2s_tdm_unit: directed table-driven bench for i2s_tdm_unit (default and 4x16 configurations)
module tb_i2s_tdm_unit;
    localparam int NC = 1160;
    localparam logic [47:0] D1 = {24'h5A5A5A, 24'hA5A5A5};
    localparam logic [47:0] D2 = {24'hC3C3C3, 24'h3C3C3C};
    localparam logic [47:0] D3 = {24'hA5A5A5, 24'h5A5A5A};

    logic        clk = 1'b0;
    logic        rst_n, play_in, fmt_in, tick_in, sel;
    logic [47:0] audio;
    logic [63:0] audio2;
    logic        req1, sck1, ws1, sdo1, und1;
    logic        req2, sck2, ws2, sdo2, und2;
    logic [4:0]  o1, o2;
    logic [4:0]  tr [NC];
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        int         s;
        int         c;
        logic [4:0] e;
    } vec_t;
    vec_t vt [32];

    assign o1 = {req1, sck1, ws1, sdo1, und1};
    assign o2 = {req2, sck2, ws2, sdo2, und2};

    always #5 clk = ~clk;

    i2s_tdm_unit dut1 (
        .clk(clk), .rst_n(rst_n), .play_in(play_in), .fmt_in(fmt_in), .audio_in(audio),
        .tick_in(tick_in), .req_out(req1), .sck_out(sck1), .ws_out(ws1), .sdo_out(sdo1),
        .underrun_out(und1)
    );

    i2s_tdm_unit #(.DATA_WIDTH(16), .CHANNELS(4), .SCK_DIV(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .play_in(play_in), .fmt_in(fmt_in), .audio_in(audio2),
        .tick_in(tick_in), .req_out(req2), .sck_out(sck2), .ws_out(ws2), .sdo_out(sdo2),
        .underrun_out(und2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        play_in = 1'b0;
        tick_in = 1'b0;
        fmt_in  = 1'b0;
        audio   = '0;
        audio2  = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // gather one trace bit at n evenly spaced cycles, first sample in the MSB
    function automatic logic [63:0] word(input int st, input int stride, input int n, input int b);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w = {w[62:0], tr[st + stride * k][b]};
        return w;
    endfunction

    function automatic int cnt(input int a, input int z, input int b);
        int n;
        n = 0;
        for (int c = a; c <= z; c++) n += int'(tr[c][b]);
        return n;
    endfunction

    // scenario s: 1 LJ, 2 I2S, 3 underrun/bypass, 4 drain LJ, 5 drain I2S, 6 4x16 config
    task automatic run(input int s);
        do_reset();
        sel    = (s == 6);
        fmt_in = (s == 2 || s == 5) ? 1'b0 : 1'b1;
        if (s >= 3) begin
            audio   = (s == 3) ? D1 : D3;
            audio2  = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
            tick_in = 1'b1;
            step();
            tick_in = 1'b0;
        end
        play_in = 1'b1;
        for (int c = 0; c < NC; c++) begin
            step();
            tr[c]   = sel ? o2 : o1;
            tick_in = 1'b0;
            if ((s == 1 || s == 2) && (c == 10 || c == 390)) begin
                audio   = D1;
                tick_in = 1'b1;
            end
            // sampled on the same edge that raises req_out at cycle 764
            if (s == 3 && c == 763) begin
                audio   = D2;
                tick_in = 1'b1;
            end
            if ((s == 4 || s == 5) && c == 100) play_in = 1'b0;
            if ((s == 4 || s == 5) && c == 300) play_in = 1'b1;
            if (s == 5 && c == 5) fmt_in = 1'b1;
        end
        play_in = 1'b0;
        tick_in = 1'b0;
        for (int i = 0; i < 32; i++)
            if (vt[i].s == s) chk($sformatf("s%0d_cyc%0d", s, vt[i].c), 64'(tr[vt[i].c]), 64'(vt[i].e));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr, ns, rises;
        // expected {req, sck, ws, sdo, underrun} at selected cycles after play start
        vt = '{
            '{1, 0, 5'b11000}, '{1, 4, 5'b00000}, '{1, 188, 5'b00100}, '{1, 379, 5'b01100},
            '{1, 380, 5'b10010}, '{1, 384, 5'b01010}, '{1, 764, 5'b10010},
            '{2, 0, 5'b11000}, '{2, 379, 5'b01100}, '{2, 380, 5'b10000}, '{2, 388, 5'b00010},
            '{2, 764, 5'b10000},
            '{3, 0, 5'b11010}, '{3, 380, 5'b10011}, '{3, 764, 5'b10000}, '{3, 1148, 5'b10001},
            '{4, 0, 5'b11000}, '{4, 379, 5'b01110}, '{4, 380, 5'b00000}, '{4, 384, 5'b00000},
            '{4, 385, 5'b11000},
            '{5, 4, 5'b00000}, '{5, 12, 5'b00010}, '{5, 380, 5'b00010}, '{5, 384, 5'b00000},
            '{5, 385, 5'b11000},
            '{6, 0, 5'b11000}, '{6, 125, 5'b01000}, '{6, 126, 5'b00110}, '{6, 253, 5'b01100},
            '{6, 254, 5'b10001}, '{6, 510, 5'b10001}
        };
        sel = 1'b0;

        // reset mid-frame clears outputs at once and leaves the unit idle
        do_reset();
        fmt_in  = 1'b1;
        play_in = 1'b1;
        for (int c = 0; c <= 200; c++) step();
        chk("pre_reset_c200", 64'(o1), 64'(5'b01100));
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'({o1, o2}), 64'd0);
        step();
        step();
        play_in = 1'b0;
        rst_n   = 1'b1;
        nr = 0;
        ns = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            nr += int'(req1);
            ns += int'(sck1);
        end
        chk("idle_req_count", 64'(nr), 64'd0);
        chk("idle_sck_count", 64'(ns), 64'd0);

        run(1);
        chk("lj_sdo_frame2", word(384, 8, 48, 1), 64'hA5A5A55A5A5A);
        chk("lj_ws_frame2", word(384, 8, 48, 2), 64'h000000FFFFFF);
        chk("lj_req_count", 64'(cnt(0, 799, 4)), 64'd3);
        chk("lj_underrun_count", 64'(cnt(0, 799, 0)), 64'd0);

        run(2);
        chk("i2s_sdo_frame2", word(392, 8, 48, 1), 64'hA5A5A55A5A5A);
        chk("i2s_ws_frame2", word(384, 8, 48, 2), 64'h000000FFFFFF);

        run(3);
        chk("underrun_repeat", word(384, 8, 48, 1), 64'hA5A5A55A5A5A);
        chk("bypass_frame", word(768, 8, 48, 1), 64'h3C3C3CC3C3C3);

        run(4);
        chk("drain_req_count", 64'(cnt(0, 384, 4)), 64'd1);
        rises = 0;
        for (int c = 1; c <= 384; c++) rises += int'(!tr[c-1][3] && tr[c][3]);
        chk("drain_sck_rises", 64'(rises), 64'd47);

        run(5);

        run(6);
        chk("tdm4_sdo_frame", word(0, 4, 64, 1), 64'h123456789ABCDEF0);
        chk("tdm4_req_count", 64'(cnt(0, 599, 4)), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
